// File: rtl/bread_slot_issuer.sv
// ---------------------------------------------------------------------------
// bread_slot_issuer
//   Issue side of a bank of NSLOT loadable down-counters. Count requests
//   arrive over a valid/ready handshake. Each accepted request is given the
//   first free slot at or after a round-robin pointer. The slot then gets a
//   registered, one-cycle, one-hot load strobe together with the count.
//
//   A slot is free when its busy flag is low and it is outside its hold
//   window. The hold window is the load cycle plus the following cycle, while
//   the counter captures the count and its busy flag becomes visible.
//
// Optional feature (compile-time macro BREAD_ISSUER_STATS_EN):
//   adds saturating 16-bit counters stat_issued (accepts) and stat_stall
//   (cycles with req_valid & ~req_ready & ena).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ena          issue enable; low blocks new accepts
//   req_valid    request present
//   req_count    count to load
//   req_ready    request accepted when req_valid & req_ready
//   slot_busy    per-slot nonzero flag from the counter bank
//   slot_load    one-hot load strobe (registered, one cycle)
//   slot_count   count accompanying slot_load (holds last value)
//   slot_idx     binary index of slot_load (0 when idle)
//   full         issuer is in the FULL state
//   stat_issued  accept counter        (BREAD_ISSUER_STATS_EN only)
//   stat_stall   stall-cycle counter   (BREAD_ISSUER_STATS_EN only)
// ---------------------------------------------------------------------------
module bread_slot_issuer #(
    parameter int NSLOT = 8,
    parameter int CW    = 4,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             req_valid,
    input  logic [CW-1:0]    req_count,
    output logic             req_ready,
    input  logic [NSLOT-1:0] slot_busy,
    output logic [NSLOT-1:0] slot_load,
    output logic [CW-1:0]    slot_count,
    output logic [IW-1:0]    slot_idx,
    output logic             full
`ifdef BREAD_ISSUER_STATS_EN
    ,
    output logic [15:0]      stat_issued,
    output logic [15:0]      stat_stall
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [NSLOT-1:0] hold_late;   // second cycle of each hold window
    logic             started;     // keeps req_ready low until the first edge after reset
    logic [NSLOT-1:0] free;
    logic             any_free;
    logic             found;
    logic [IW-1:0]    sel;
    logic [NSLOT-1:0] sel_onehot;
    logic             accept;

    // The first cycle of the hold window is exactly the load cycle, so the
    // registered strobe doubles as that part of the hold mask.
    assign free      = ~slot_busy & ~slot_load & ~hold_late;
    assign any_free  = |free;
    assign req_ready = started & ena & any_free & (state != S_FULL);
    assign accept    = req_valid & req_ready;

    // Round-robin search: first free slot at or after rr_ptr, wrapping.
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NSLOT; k++) begin
            int cand;
            cand = (int'(rr_ptr) + k) % NSLOT;
            if (!found && free[cand]) begin
                found = 1'b1;
                sel   = IW'(cand);
            end
        end
    end

    assign sel_onehot = {{(NSLOT-1){1'b0}}, 1'b1} << sel;

    always_comb begin
        state_nxt = state;
        if (!ena) begin
            state_nxt = S_IDLE;
        end else if (state == S_FULL) begin
            if (any_free) state_nxt = S_IDLE;
        end else if (accept) begin
            state_nxt = S_ISSUE;
        end else if (req_valid && !any_free) begin
            state_nxt = S_FULL;
        end else if (!req_valid) begin
            state_nxt = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            full       <= 1'b0;
            rr_ptr     <= '0;
            hold_late  <= '0;
            started    <= 1'b0;
            slot_load  <= '0;
            slot_count <= '0;
            slot_idx   <= '0;
        end else begin
            started   <= 1'b1;
            state     <= state_nxt;
            full      <= (state_nxt == S_FULL);
            hold_late <= slot_load;
            if (accept) begin
                slot_load  <= sel_onehot;
                slot_count <= req_count;
                slot_idx   <= sel;
                rr_ptr     <= (int'(sel) == NSLOT - 1) ? '0 : sel + IW'(1);
            end else begin
                slot_load  <= '0;
                slot_idx   <= '0;
            end
        end
    end

`ifdef BREAD_ISSUER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept && stat_issued != 16'hFFFF)
                stat_issued <= stat_issued + 16'd1;
            if (req_valid && !req_ready && ena && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bread_slot_issuer.sv
// ---------------------------------------------------------------------------
// tb_bread_slot_issuer
//   Directed bench for bread_slot_issuer (NSLOT=8, CW=4, IW=3). Each step
//   drives inputs on the falling edge, checks req_ready before the rising
//   edge and queues the expected load on an accept. It then checks the
//   registered outputs 1 ns after the rising edge against the queue head.
//   Build with BREAD_ISSUER_STATS_EN to exercise the stat ports as well.
// ---------------------------------------------------------------------------
module tb_bread_slot_issuer;

    typedef struct packed {
        logic [7:0] load;
        logic [3:0] cnt;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       req_valid;
    logic [3:0] req_count;
    logic       req_ready;
    logic [7:0] slot_busy;
    logic [7:0] slot_load;
    logic [3:0] slot_count;
    logic [2:0] slot_idx;
    logic       full;
`ifdef BREAD_ISSUER_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_stall;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bread_slot_issuer #(.NSLOT(8), .CW(4), .IW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .slot_busy  (slot_busy),
        .slot_load  (slot_load),
        .slot_count (slot_count),
        .slot_idx   (slot_idx),
        .full       (full)
`ifdef BREAD_ISSUER_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall (stat_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] idx_of(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
        return r;
    endfunction

    // Registered outputs after an edge: either the queued grant or idle.
    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".load"},  32'(slot_load),  32'(e.load));
            check({tag, ".count"}, 32'(slot_count), 32'(e.cnt));
            check({tag, ".idx"},   32'(slot_idx),   32'(e.idx));
        end else begin
            check({tag, ".noload"}, 32'(slot_load), 32'd0);
            check({tag, ".idx0"},   32'(slot_idx),  32'd0);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] c,
                        input logic [7:0] b, input logic exp_rdy, input logic [7:0] exp_slot);
        exp_t e;
        @(negedge clk);
        req_valid = v;
        req_count = c;
        slot_busy = b;
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            e.load = exp_slot;
            e.cnt  = c;
            e.idx  = idx_of(exp_slot);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        req_valid = 1'b0;
        req_count = '0;
        slot_busy = '0;
        #12;
        check("rst.load",  32'(slot_load),  32'd0);
        check("rst.count", 32'(slot_count), 32'd0);
        check("rst.idx",   32'(slot_idx),   32'd0);
        check("rst.full",  32'(full),       32'd0);
        check("rst.ready", 32'(req_ready),  32'd0);
`ifdef BREAD_ISSUER_STATS_EN
        check("rst.issued", 32'(stat_issued), 32'd0);
        check("rst.stall",  32'(stat_stall),  32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.ready", 32'(req_ready), 32'd0);

        // 1: single request, one-cycle strobe, count holds afterwards
        step("t1.acc",  1'b1, 4'd5, 8'h00, 1'b1, 8'h01);
        step("t1.idle", 1'b0, 4'd0, 8'h00, 1'b1, 8'h00);
        check("t1.count_hold", 32'(slot_count), 32'd5);

        // 2: back-to-back accepts walk round-robin
        do_reset();
        step("t2.a", 1'b1, 4'd1, 8'h00, 1'b1, 8'h01);
        step("t2.b", 1'b1, 4'd2, 8'h00, 1'b1, 8'h02);
        step("t2.c", 1'b1, 4'd3, 8'h00, 1'b1, 8'h04);
        step("t2.d", 1'b0, 4'd0, 8'h00, 1'b1, 8'h00);

        // 3: all busy -> FULL, one bubble after busy[5] falls, then slot 5
        step("t3.full0", 1'b1, 4'd7, 8'hFF, 1'b0, 8'h00);
        check("t3.full_set", 32'(full), 32'd1);
        step("t3.full1", 1'b1, 4'd7, 8'hFF, 1'b0, 8'h00);
        check("t3.full_hold", 32'(full), 32'd1);
        step("t3.bubble", 1'b1, 4'd7, 8'hDF, 1'b0, 8'h00);
        check("t3.full_clr", 32'(full), 32'd0);
        step("t3.acc", 1'b1, 4'd7, 8'hDF, 1'b1, 8'h20);

        // 4: drive rr_ptr to 7, take slot 7, then wrap to slot 0
        step("t4.s6", 1'b1, 4'd1, 8'hBF, 1'b1, 8'h40);
        step("t4.s7", 1'b1, 4'd2, 8'h7F, 1'b1, 8'h80);
        step("t4.s0", 1'b1, 4'd3, 8'hFE, 1'b1, 8'h01);

        // 5: zero count into slot 0 (search wraps from rr_ptr=1); free again 2 cycles later
        step("t5.gap0", 1'b0, 4'd0, 8'hFF, 1'b0, 8'h00);
        step("t5.gap1", 1'b0, 4'd0, 8'hFF, 1'b0, 8'h00);
        step("t5.acc0", 1'b1, 4'd0, 8'hFE, 1'b1, 8'h01);
        step("t5.hold0", 1'b0, 4'd0, 8'hFE, 1'b0, 8'h00);
        step("t5.hold1", 1'b0, 4'd0, 8'hFE, 1'b0, 8'h00);
        step("t5.regrant", 1'b1, 4'd3, 8'hFE, 1'b1, 8'h01);

        // ena low blocks the accept and sends the FSM to IDLE
        ena = 1'b0;
        step("ena.off", 1'b1, 4'd2, 8'h00, 1'b0, 8'h00);
        check("ena.full", 32'(full), 32'd0);
        ena = 1'b1;

        // 6: reset asserted during a load cycle clears outputs at once
        step("t6.acc", 1'b1, 4'd9, 8'h00, 1'b1, 8'h02);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("t6.async_load",  32'(slot_load),  32'd0);
        check("t6.async_count", 32'(slot_count), 32'd0);
        check("t6.async_idx",   32'(slot_idx),   32'd0);
`ifdef BREAD_ISSUER_STATS_EN
        check("t6.issued", 32'(stat_issued), 32'd0);
        check("t6.stall",  32'(stat_stall),  32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("t6.first", 1'b1, 4'd4, 8'h00, 1'b1, 8'h01);
        step("t6.end",   1'b0, 4'd0, 8'h00, 1'b1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
